// File: rtl/imem_dual_port_arbiter_pkg.sv
// Memory message definitions shared by the instruction-memory arbiter slice:
// message sizes, field positions and request type encodings.
package imem_dual_port_arbiter_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    localparam int unsigned TYPE_SZ = 1;
    localparam int unsigned LEN_SZ  = 2;

    // Default-parameter sizes (32-bit address and data).
    localparam int unsigned REQ_SZ  = TYPE_SZ + 32 + LEN_SZ + 32;
    localparam int unsigned RESP_SZ = TYPE_SZ + LEN_SZ + 32;

    function automatic int unsigned req_sz(int unsigned addr_sz, int unsigned data_sz);
        return TYPE_SZ + addr_sz + LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned resp_sz(int unsigned data_sz);
        return TYPE_SZ + LEN_SZ + data_sz;
    endfunction

    // Request layout {type, addr, len, data}: bit positions of each field.
    function automatic int unsigned req_type_bit(int unsigned addr_sz, int unsigned data_sz);
        return addr_sz + LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned req_addr_lsb(int unsigned data_sz);
        return LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned req_len_lsb(int unsigned data_sz);
        return data_sz;
    endfunction

    // Response layout {type, len, data}.
    function automatic int unsigned resp_type_bit(int unsigned data_sz);
        return LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned resp_len_lsb(int unsigned data_sz);
        return data_sz;
    endfunction

endpackage

// File: rtl/imem_dual_port_arbiter_if.sv
// One val/rdy memory channel: a request stream out and a response stream back.
interface imem_dual_port_arbiter_if
    import imem_dual_port_arbiter_pkg::*;
#(
    parameter int unsigned p_addr_sz = 32,
    parameter int unsigned p_data_sz = 32
);
    localparam int unsigned REQ_W  = req_sz(p_addr_sz, p_data_sz);
    localparam int unsigned RESP_W = resp_sz(p_data_sz);

    logic              req_val;
    logic              req_rdy;
    logic [REQ_W-1:0]  req_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_msg;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/imem_tag_fifo.sv
// 1-bit-wide tag FIFO remembering which fetch port issued each outstanding request.
module imem_tag_fifo #(
    parameter int unsigned p_depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_id
);
    localparam int unsigned PW = $clog2(p_depth);
    localparam int unsigned CW = PW + 1;

    logic [p_depth-1:0] tags;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tags[tail] <= push_id;
                tail       <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == CW'(p_depth));
    assign empty   = (count == '0);
    assign head_id = tags[head];

endmodule

// File: rtl/imem_dual_port_arbiter.sv
// Round-robin merge of two fetch ports onto one in-order memory port, with
// responses steered back by a tag FIFO of issuing port ids.
module imem_dual_port_arbiter
    import imem_dual_port_arbiter_pkg::*;
#(
    parameter int unsigned p_addr_sz         = 32,
    parameter int unsigned p_data_sz         = 32,
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    imem_dual_port_arbiter_if.slave     core0,
    imem_dual_port_arbiter_if.slave     core1,
    imem_dual_port_arbiter_if.master    mem,
    output logic                        err
);
    logic last_grant;
    logic grant;
    logic any_val;
    logic full;
    logic empty;
    logic head_id;
    logic push;
    logic pop;
    logic drop;

    // The core always accepts responses, so its response-ready is ignored.
    logic unused_core_resp_rdy;
    assign unused_core_resp_rdy = core0.resp_rdy & core1.resp_rdy;

    always_comb begin
        any_val = core0.req_val | core1.req_val;
        if (core0.req_val && core1.req_val) begin
            grant = ~last_grant;
        end else begin
            grant = core1.req_val;
        end
    end

    // Everything toward the core and memory is held quiet while reset is low.
    assign mem.req_val    = reset & any_val & ~full;
    assign mem.req_msg    = grant ? core1.req_msg : core0.req_msg;
    assign core0.req_rdy  = reset & ~grant & mem.req_rdy & ~full;
    assign core1.req_rdy  = reset &  grant & mem.req_rdy & ~full;
    assign mem.resp_rdy   = 1'b1;

    assign push = mem.req_val & mem.req_rdy;
    assign pop  = reset & mem.resp_val & ~empty;
    assign drop = reset & mem.resp_val &  empty;

    assign core0.resp_val = pop & ~head_id;
    assign core1.resp_val = pop &  head_id;
    assign core0.resp_msg = mem.resp_msg;
    assign core1.resp_msg = mem.resp_msg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
            err        <= 1'b0;
        end else begin
            if (push) begin
                last_grant <= grant;
            end
            if (drop) begin
                err <= 1'b1;
            end
        end
    end

    imem_tag_fifo #(
        .p_depth (p_max_outstanding)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (grant),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head_id (head_id)
    );

endmodule

// File: tb/tb_imem_dual_port_arbiter.sv
// Bench for imem_dual_port_arbiter: directed vector table, hand sequences and
// randomized traffic checked against a queue-based model of outstanding requests.
module tb_imem_dual_port_arbiter;
    import imem_dual_port_arbiter_pkg::*;

    localparam int unsigned ADDR   = 32;
    localparam int unsigned DATA   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned REQ_W  = req_sz(ADDR, DATA);
    localparam int unsigned RESP_W = resp_sz(DATA);

    typedef struct {
        bit rst, r0v, r1v, mrdy, mrv;
        bit mval, rdy0, rdy1, rv0, rv1, err, gnt;
    } vec_t;

    logic clk;
    logic reset;
    logic err;

    imem_dual_port_arbiter_if #(.p_addr_sz(ADDR), .p_data_sz(DATA)) core0_if ();
    imem_dual_port_arbiter_if #(.p_addr_sz(ADDR), .p_data_sz(DATA)) core1_if ();
    imem_dual_port_arbiter_if #(.p_addr_sz(ADDR), .p_data_sz(DATA)) mem_if ();

    imem_dual_port_arbiter #(
        .p_addr_sz         (ADDR),
        .p_data_sz         (DATA),
        .p_max_outstanding (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .core0 (core0_if),
        .core1 (core1_if),
        .mem   (mem_if),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: ordered list of issuing port ids, last accepted port, sticky error.
    bit mq[$];
    bit m_lg  = 1'b1;
    bit m_err = 1'b0;

    vec_t tbl[22];

    function automatic vec_t mk(bit rst, bit r0v, bit r1v, bit mrdy, bit mrv,
                                bit mval, bit rdy0, bit rdy1, bit rv0, bit rv1,
                                bit e, bit gnt);
        vec_t v;
        v.rst = rst; v.r0v = r0v; v.r1v = r1v; v.mrdy = mrdy; v.mrv = mrv;
        v.mval = mval; v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
        v.err = e; v.gnt = gnt;
        return v;
    endfunction

    function automatic logic [REQ_W-1:0] mk_req(mem_type_e t, logic [ADDR-1:0] a,
                                                logic [DATA-1:0] d);
        return {t, a, 2'b00, d};
    endfunction

    function automatic logic [REQ_W-1:0] rnd_req();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[REQ_W-1:0];
    endfunction

    function automatic logic [RESP_W-1:0] rnd_resp();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[RESP_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit r0v, input bit r1v, input bit mrdy,
                        input bit mrv, input logic [REQ_W-1:0] m0,
                        input logic [REQ_W-1:0] m1, input logic [RESP_W-1:0] rm,
                        input bit use_tbl, input vec_t tv, input string tag);
        bit full, gnt, e_mval, e_rdy0, e_rdy1, e_rv0, e_rv1, e_err;
        @(negedge clk);
        reset            = rst;
        core0_if.req_val = r0v;
        core0_if.req_msg = m0;
        core1_if.req_val = r1v;
        core1_if.req_msg = m1;
        mem_if.req_rdy   = mrdy;
        mem_if.resp_val  = mrv;
        mem_if.resp_msg  = rm;
        #1;
        full   = (mq.size() == DEPTH);
        gnt    = (r0v && r1v) ? !m_lg : r1v;
        e_mval = 0; e_rdy0 = 0; e_rdy1 = 0; e_rv0 = 0; e_rv1 = 0;
        if (rst) begin
            e_mval = (r0v || r1v) && !full;
            e_rdy0 = !gnt && mrdy && !full;
            e_rdy1 =  gnt && mrdy && !full;
            if (mrv && mq.size() > 0) begin
                e_rv0 = (mq[0] == 1'b0);
                e_rv1 = (mq[0] == 1'b1);
            end
        end
        e_err = m_err;
        if (use_tbl) begin
            e_mval = tv.mval; e_rdy0 = tv.rdy0; e_rdy1 = tv.rdy1;
            e_rv0 = tv.rv0; e_rv1 = tv.rv1; e_err = tv.err; gnt = tv.gnt;
        end
        chk({tag, " memreq_val"}, 128'(mem_if.req_val), 128'(e_mval));
        chk({tag, " req0_rdy"}, 128'(core0_if.req_rdy), 128'(e_rdy0));
        chk({tag, " req1_rdy"}, 128'(core1_if.req_rdy), 128'(e_rdy1));
        chk({tag, " resp0_val"}, 128'(core0_if.resp_val), 128'(e_rv0));
        chk({tag, " resp1_val"}, 128'(core1_if.resp_val), 128'(e_rv1));
        chk({tag, " err"}, 128'(err), 128'(e_err));
        chk({tag, " memresp_rdy"}, 128'(mem_if.resp_rdy), 128'(1'b1));
        if (e_mval) chk({tag, " memreq_msg"}, 128'(mem_if.req_msg), 128'(gnt ? m1 : m0));
        if (e_rv0)  chk({tag, " resp0_msg"}, 128'(core0_if.resp_msg), 128'(rm));
        if (e_rv1)  chk({tag, " resp1_msg"}, 128'(core1_if.resp_msg), 128'(rm));
        // Advance the model to the state after the coming clock edge.
        if (!rst) begin
            mq.delete();
            m_lg  = 1'b1;
            m_err = 1'b0;
        end else begin
            if (mrv) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_err = 1'b1;
            end
            if ((r0v || r1v) && !full && mrdy) begin
                mq.push_back(gnt);
                m_lg = gnt;
            end
        end
    endtask

    task automatic mstep(input bit rst, input bit r0v, input bit r1v, input bit mrdy,
                         input bit mrv, input string tag);
        vec_t none;
        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(rst, r0v, r1v, mrdy, mrv, rnd_req(), rnd_req(), rnd_resp(), 1'b0, none, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t none;
        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            rst r0 r1 rdy mrv | mval rdy0 rdy1 rv0 rv1 err gnt
        tbl[0]  = mk(0, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 1, 1,   0, 1, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0, 1);
        tbl[4]  = mk(1, 1, 1, 1, 1,   1, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0, 1);
        tbl[8]  = mk(1, 1, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, 1, 1, 1,   0, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(1, 1, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(1, 0, 0, 1, 1,   0, 1, 0, 1, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 1, 1,   0, 1, 0, 0, 1, 0, 0);
        tbl[15] = mk(1, 0, 0, 1, 1,   0, 1, 0, 1, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 1, 0);
        tbl[18] = mk(1, 0, 1, 1, 0,   1, 0, 1, 0, 0, 1, 1);
        tbl[19] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(1, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 1, 0);

        reset            = 1'b0;
        core0_if.req_val = 1'b0;
        core0_if.req_msg = '0;
        core0_if.resp_rdy = 1'b1;
        core1_if.req_val = 1'b0;
        core1_if.req_msg = '0;
        core1_if.resp_rdy = 1'b1;
        mem_if.req_rdy   = 1'b0;
        mem_if.resp_val  = 1'b0;
        mem_if.resp_msg  = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].r0v, tbl[i].r1v, tbl[i].mrdy, tbl[i].mrv,
                 rnd_req(), rnd_req(), rnd_resp(), 1'b1, tbl[i], $sformatf("vec%0d", i));
        end

        // Port 0 alone: read 0x1000, response 0xDEADBEEF the next cycle.
        mstep(1'b0, 0, 0, 1, 0, "p0 rst");
        step(1'b1, 1, 0, 1, 0, mk_req(MEM_READ, 32'h1000, '0), rnd_req(), rnd_resp(),
             1'b0, none, "p0 req");
        step(1'b1, 0, 0, 1, 1, rnd_req(), rnd_req(), {MEM_READ, 2'b00, 32'hDEADBEEF},
             1'b0, none, "p0 resp");

        // Both ports every cycle with interleaved addresses; responses follow one behind.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1, 1, 1, (i > 0), mk_req(MEM_READ, 32'(8 * i), '0),
                 mk_req(MEM_READ, 32'(8 * i + 4), '0), rnd_resp(), 1'b0, none,
                 $sformatf("alt%0d", i));
        end
        mstep(1'b1, 0, 0, 1, 1, "alt drain");

        // Downstream stalled for 5 cycles, then contention resolves without a change of turn.
        for (int i = 0; i < 5; i++) mstep(1'b1, 1, 1, 0, 0, $sformatf("stall%0d", i));
        mstep(1'b1, 1, 1, 1, 0, "stall release");
        mstep(1'b1, 0, 0, 1, 1, "stall drain");

        // Reset with three outstanding requests; a late response flags err.
        for (int i = 0; i < 3; i++) mstep(1'b1, 1, 0, 1, 0, $sformatf("pre%0d", i));
        mstep(1'b0, 0, 0, 1, 0, "mid rst");
        mstep(1'b1, 0, 0, 1, 1, "late resp");
        mstep(1'b1, 1, 1, 1, 0, "post rst contend");
        mstep(1'b1, 0, 0, 1, 0, "err hold");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit rst, mrv;
            rst = ($urandom_range(0, 99) != 0);
            mrv = (mq.size() > 0) ? bit'($urandom_range(0, 1))
                                  : ($urandom_range(0, 19) == 0);
            mstep(rst, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), mrv, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
